// File: rtl/dispatch_scheduler_if.sv
// dispatch_scheduler_if: decoded-instruction type plus the ID/RS/ROB-facing bundle of the dispatch queue.
package dispatch_pkg;
    localparam int UW = 3;
    typedef struct packed {
        logic          is_valid;
        logic [UW-1:0] unit_id;
        logic [7:0]    op;
        logic [31:0]   pc;
    } decode_result_t;
endpackage

interface dispatch_scheduler_if import dispatch_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int NUM_UNITS = 4
);
    logic                       flush;
    decode_result_t [1:0]       in_decoded;
    logic                       in_ready;
    logic [NUM_UNITS-1:0]       rs_rdy;
    logic [1:0]                 rob_free;
    logic [1:0]                 disp_valid;
    decode_result_t [1:0]       disp_instr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output flush, in_decoded, rs_rdy, rob_free,
        input  in_ready, disp_valid, disp_instr, count
    );
    modport slave (
        input  flush, in_decoded, rs_rdy, rob_free,
        output in_ready, disp_valid, disp_instr, count
    );
endinterface

// File: rtl/dispatch_scheduler.sv
// dispatch_scheduler: in-order circular queue taking up to two decoded instructions per cycle
// and dispatching up to two per cycle to the reservation stations, gated by RS space and ROB slots.
module dispatch_scheduler import dispatch_pkg::*; #(
    parameter int DEPTH = 8,
    parameter int NUM_UNITS = 4
) (
    input logic clk,
    input logic reset,
    dispatch_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UXW = 1 << UW;

    decode_result_t mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [UXW-1:0] rdy;
    decode_result_t e0, e1, o0, o1;
    logic has0, has1, d0, d1, v0, v1, in_ready;
    logic [1:0] enq_n, disp_n;

    // Zero-extended so unit indices beyond NUM_UNITS read as never ready.
    assign rdy = UXW'(bus.rs_rdy);
    assign has0 = count != '0;
    assign has1 = count >= CW'(2);
    assign e0 = has0 ? mem[head] : '0;
    assign e1 = has1 ? mem[head + AW'(1)] : '0;
    assign d0 = has0 && rdy[e0.unit_id] && (bus.rob_free != 2'd0) && !bus.flush;
    assign d1 = d0 && has1 && rdy[e1.unit_id] && bus.rob_free[1] && (e1.unit_id != e0.unit_id);
    assign in_ready = (count <= CW'(DEPTH - 2)) && !bus.flush;
    assign v0 = bus.in_decoded[0].is_valid;
    assign v1 = bus.in_decoded[1].is_valid;
    assign enq_n = in_ready ? {1'b0, v0} + {1'b0, v1} : 2'd0;
    assign disp_n = {1'b0, d0} + {1'b0, d1};

    always_comb begin
        o0 = e0;
        o0.is_valid = d0;
        o1 = e1;
        o1.is_valid = d1;
    end

    assign bus.in_ready = in_ready;
    assign bus.disp_valid = {d1, d0};
    assign bus.disp_instr = {o1, o0};
    assign bus.count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + AW'(disp_n);
            tail <= tail + AW'(enq_n);
            count <= count + CW'(enq_n) - CW'(disp_n);
        end
    end

    // Valid slots are packed in order so a lone slot-1 instruction lands at tail.
    always_ff @(posedge clk) begin
        if (in_ready) begin
            if (v0) mem[tail] <= bus.in_decoded[0];
            if (v1) mem[v0 ? tail + AW'(1) : tail] <= bus.in_decoded[1];
        end
    end

    a_unit_range: assert property (@(posedge clk) disable iff (reset)
        has0 |-> int'(e0.unit_id) < NUM_UNITS);
endmodule

// File: tb/tb_dispatch_scheduler.sv
// tb_dispatch_scheduler: directed sequence with a pc scoreboard checking in-order, lossless dispatch.
module tb_dispatch_scheduler;
    import dispatch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] sb [$];
    logic [31:0] pc_n = 32'h100;
    logic [31:0] first_pc;

    dispatch_scheduler_if #(.DEPTH(8), .NUM_UNITS(4)) bus ();
    dispatch_scheduler #(.DEPTH(8), .NUM_UNITS(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic decode_result_t mk(input logic v, input int u, input logic [31:0] pc);
        decode_result_t d;
        d = '0;
        d.is_valid = v;
        d.unit_id = UW'(u);
        d.op = 8'h5a;
        d.pc = pc;
        return d;
    endfunction

    task automatic send(input logic a, input int ua, input logic b, input int ub);
        bus.in_decoded[0] = mk(a, ua, pc_n);
        bus.in_decoded[1] = mk(b, ub, pc_n + 32'd4);
        pc_n += 32'd8;
    endtask

    task automatic idle();
        bus.in_decoded = '0;
    endtask

    task automatic adv();
        #1;
        for (int i = 0; i < 2; i++)
            if (bus.disp_valid[i]) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) chk("disp_pc", 64'(bus.disp_instr[i].pc), 64'(sb.pop_front()));
            end
        if (bus.flush) sb.delete();
        else if (bus.in_ready) begin
            if (bus.in_decoded[0].is_valid) sb.push_back(bus.in_decoded[0].pc);
            if (bus.in_decoded[1].is_valid) sb.push_back(bus.in_decoded[1].pc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && bus.count != 0; i++) adv();
        chk(tag, 64'(bus.count), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.rs_rdy = 4'b1111;
        bus.rob_free = 2'd2;
        idle();
        @(negedge clk);
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_disp_valid", 64'(bus.disp_valid), 64'd0);
        chk("rst_disp_instr", 64'(bus.disp_instr), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // same-unit pair dispatches one per cycle
        send(1, 1, 1, 1);
        #1;
        chk("t1_no_forward", 64'(bus.disp_valid), 64'd0);
        adv();
        idle();
        #1;
        chk("t1_count2", 64'(bus.count), 64'd2);
        chk("t1_dv_a", 64'(bus.disp_valid), 64'b01);
        chk("t1_e1_masked", 64'(bus.disp_instr[1].is_valid), 64'd0);
        adv();
        chk("t1_count1", 64'(bus.count), 64'd1);
        chk("t1_dv_b", 64'(bus.disp_valid), 64'b01);
        adv();
        chk("t1_count0", 64'(bus.count), 64'd0);

        // steady dual dispatch
        send(1, 0, 1, 2);
        adv();
        for (int k = 0; k < 4; k++) begin
            send(1, 0, 1, 2);
            #1;
            chk("t2_dv", 64'(bus.disp_valid), 64'b11);
            chk("t2_count", 64'(bus.count), 64'd2);
            chk("t2_in_ready", 64'(bus.in_ready), 64'd1);
            adv();
        end
        idle();
        drain("t2_drain");

        // fill to full with RS stalled
        bus.rs_rdy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            send(1, 0, 1, 1);
            #1;
            chk("t3_count", 64'(bus.count), 64'(2 * k));
            chk("t3_in_ready", 64'(bus.in_ready), 64'd1);
            adv();
        end
        send(1, 0, 1, 1);
        #1;
        chk("t3_full_count", 64'(bus.count), 64'd8);
        chk("t3_full_ready", 64'(bus.in_ready), 64'd0);
        chk("t3_full_dv", 64'(bus.disp_valid), 64'd0);
        adv();
        bus.rs_rdy = 4'b0001;
        #1;
        chk("t3_dv_one", 64'(bus.disp_valid), 64'b01);
        adv();
        chk("t3_count7", 64'(bus.count), 64'd7);
        chk("t3_ready7", 64'(bus.in_ready), 64'd0);
        chk("t3_head_blocked", 64'(bus.disp_valid), 64'd0);
        idle();
        bus.rs_rdy = 4'b1111;
        drain("t3_drain");

        // program order and ROB limits
        send(1, 3, 1, 0);
        adv();
        idle();
        bus.rs_rdy = 4'b0001;
        #1;
        chk("t4_in_order", 64'(bus.disp_valid), 64'd0);
        adv();
        bus.rs_rdy = 4'b1111;
        bus.rob_free = 2'd0;
        #1;
        chk("t4_rob0", 64'(bus.disp_valid), 64'd0);
        adv();
        bus.rob_free = 2'd1;
        #1;
        chk("t4_rob1", 64'(bus.disp_valid), 64'b01);
        chk("t4_rob1_unit", 64'(bus.disp_instr[0].unit_id), 64'd3);
        adv();
        bus.rob_free = 2'd3;
        #1;
        chk("t4_rob3", 64'(bus.disp_valid), 64'b01);
        chk("t4_count1", 64'(bus.count), 64'd1);
        adv();
        bus.rob_free = 2'd2;
        chk("t4_count0", 64'(bus.count), 64'd0);

        // flush discards queue and incoming pair
        bus.rs_rdy = 4'b0000;
        send(1, 0, 1, 2);
        adv();
        send(1, 0, 1, 2);
        adv();
        send(1, 0, 0, 2);
        adv();
        send(1, 0, 1, 2);
        bus.flush = 1'b1;
        bus.rs_rdy = 4'b1111;
        #1;
        chk("t5_count5", 64'(bus.count), 64'd5);
        chk("t5_flush_dv", 64'(bus.disp_valid), 64'd0);
        chk("t5_flush_ready", 64'(bus.in_ready), 64'd0);
        adv();
        bus.flush = 1'b0;
        first_pc = pc_n;
        send(1, 0, 1, 2);
        #1;
        chk("t5_post_count", 64'(bus.count), 64'd0);
        chk("t5_post_ready", 64'(bus.in_ready), 64'd1);
        adv();
        idle();
        #1;
        chk("t5_first_pc", 64'(bus.disp_instr[0].pc), 64'(first_pc));
        chk("t5_first_dv", 64'(bus.disp_valid), 64'b11);
        adv();

        // wrap: head/tail now at 2; single slot-1 entry lands at index 7
        bus.rs_rdy = 4'b0000;
        send(1, 0, 1, 1);
        adv();
        send(1, 0, 1, 1);
        adv();
        send(1, 0, 0, 1);
        adv();
        send(0, 0, 1, 1);
        #1;
        chk("t6_count5", 64'(bus.count), 64'd5);
        adv();
        send(1, 0, 1, 1);
        #1;
        chk("t6_count6", 64'(bus.count), 64'd6);
        adv();
        chk("t6_count8", 64'(bus.count), 64'd8);
        idle();
        bus.rs_rdy = 4'b1111;
        drain("t6_drain");

        // asynchronous reset between edges
        bus.rs_rdy = 4'b0000;
        send(1, 0, 1, 2);
        adv();
        idle();
        bus.rs_rdy = 4'b1111;
        #1;
        chk("t6_pre_rst_dv", 64'(bus.disp_valid), 64'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_dv", 64'(bus.disp_valid), 64'd0);
        chk("t6_async_count", 64'(bus.count), 64'd0);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t6_after_rst_count", 64'(bus.count), 64'd0);
        chk("sb_leftover", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
